// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM main controller: Moore FSM with memory-handshake wait states.
// Optional retired-instruction counter enabled by MCTRL_RETIRE_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic [1:0]         ImmSrc,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
`ifdef MCTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]        retired_cnt
`endif
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMRD    = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWR    = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        UNKNOWN  = STATE_W'(10)
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_imm_src;
    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_unused;

    assign w_unused = ^Funct[2:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_imm_src <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE)
                r_imm_src <= Op;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_irwrite = 1'b0;
        w_nextpc  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_branch  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        illegal   = 1'b0;
        unique case (r_state)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_nextpc  = mem_ready;
                if (mem_ready)
                    w_next = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (Op)
                    2'b00:   w_next = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   w_next = MEMADR;
                    2'b10:   w_next = BRANCH;
                    default: w_next = UNKNOWN;
                endcase
            end
            EXECUTER: begin
                ALUOp  = 1'b1;
                w_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                w_next  = ALUWB;
            end
            ALUWB: begin
                // compare/test ops only update flags
                w_regw = (Funct[4:3] != 2'b10);
                w_next = FETCH;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ready)
                    w_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
                w_next    = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
                if (mem_ready)
                    w_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
                w_next    = FETCH;
            end
            UNKNOWN: begin
                illegal = 1'b1;
                w_next  = UNKNOWN;
            end
            default: w_next = UNKNOWN;
        endcase
    end

    assign IRWrite   = w_irwrite & ~reset;
    assign NextPC    = w_nextpc & ~reset;
    assign RegW      = w_regw & ~reset;
    assign MemW      = w_memw & ~reset;
    assign Branch    = w_branch & ~reset;
    assign ImmSrc    = r_imm_src;
    assign state_dbg = r_state;

`ifdef MCTRL_RETIRE_CNT_EN
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = (w_next == FETCH) &&
                      ((r_state == ALUWB) || (r_state == MEMWB) ||
                       (r_state == MEMWR) || (r_state == BRANCH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retired <= 32'd0;
        else if (w_retire)
            r_retired <= r_retired + 32'd1;
    end

    assign retired_cnt = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm against an instruction-level
// reference that expands each instruction into its expected state trace.
module tb_multicycle_ctrl_fsm;

    logic        clk;
    logic        reset;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic        mem_ready;
    logic        IRWrite;
    logic        NextPC;
    logic        RegW;
    logic        MemW;
    logic        Branch;
    logic        AdrSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic        ALUOp;
    logic [1:0]  ImmSrc;
    logic        illegal;
    logic [3:0]  state_dbg;
`ifdef MCTRL_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    int          n_vec;
    int          n_err;
    logic [1:0]  m_imm;
    logic [31:0] m_cnt;
    logic [14:0] got_vec;

    multicycle_ctrl_fsm #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .mem_ready (mem_ready),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .illegal   (illegal),
        .state_dbg (state_dbg)
`ifdef MCTRL_RETIRE_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    assign got_vec = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
                      ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Output table for a state (numbers as listed in the state table)
    function automatic logic [14:0] exp_out(input int s, input bit mr,
                                            input logic [5:0] f);
        bit irw = 0, npc = 0, rw = 0, mw = 0, br = 0;
        bit adr = 0, aop = 0, ill = 0;
        logic [1:0] a = 0, b = 0, rs = 0;
        case (s)
            0: begin a = 1; b = 2; rs = 2; irw = mr; npc = mr; end
            1: begin a = 1; b = 2; rs = 2; end
            2: b = 1;
            3: adr = 1;
            4: begin rs = 1; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6: aop = 1;
            7: begin b = 1; aop = 1; end
            8: rw = (f[4:3] != 2'b10);
            9: begin a = 2; b = 1; rs = 2; br = 1; end
            10: ill = 1;
            default: ;
        endcase
        return {irw, npc, rw, mw, br, adr, a, b, rs, aop, ill};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic step(input int s, input bit mr);
        mem_ready = mr;
        #1;
        chk("state", 32'(state_dbg), 32'(s));
        chk("outs", 32'(got_vec), 32'(exp_out(s, mr, Funct)));
        chk("imm", 32'(ImmSrc), 32'(m_imm));
`ifdef MCTRL_RETIRE_CNT_EN
        chk("retired", retired_cnt, m_cnt);
`endif
        if (s == 1)
            m_imm = Op;
        if (s == 8 || s == 4 || s == 9 || (s == 5 && mr))
            m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input int kf, input int km);
        Op    = op;
        Funct = fn;
        repeat (kf) step(0, 0);
        step(0, 1);
        step(1, rb());
        case (op)
            2'b00: begin
                step(fn[5] ? 7 : 6, rb());
                step(8, rb());
            end
            2'b01: begin
                step(2, rb());
                if (fn[0]) begin
                    repeat (km) step(3, 0);
                    step(3, 1);
                    step(4, rb());
                end else begin
                    repeat (km) step(5, 0);
                    step(5, 1);
                end
            end
            2'b10: step(9, rb());
            default: repeat (20) step(10, rb());
        endcase
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        m_imm     = 2'b00;
        m_cnt     = 32'd0;
        repeat (3) begin
            #1;
            chk("rst_state", 32'(state_dbg), 32'd0);
            chk("rst_en", 32'({IRWrite, NextPC, RegW, MemW, Branch}), 32'd0);
            chk("rst_imm", 32'(ImmSrc), 32'd0);
`ifdef MCTRL_RETIRE_CNT_EN
            chk("rst_retired", retired_cnt, 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic rand_instr();
        int          kind;
        logic [5:0]  fn;
        kind = int'($urandom_range(0, 2));
        fn   = 6'($urandom);
        case (kind)
            0: run_instr(2'b00, fn, int'($urandom_range(0, 2)), 0);
            1: run_instr(2'b01, fn, int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 3)));
            default: run_instr(2'b10, fn, int'($urandom_range(0, 2)), 0);
        endcase
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        Op        = 2'b00;
        Funct     = 6'b000000;
        mem_ready = 1'b1;
        m_imm     = 2'b00;
        m_cnt     = 32'd0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(2'b00, 6'b001000, 0, 0);
        run_instr(2'b00, 6'b110101, 0, 0);
        run_instr(2'b01, 6'b011001, 0, 2);
        run_instr(2'b01, 6'b011000, 0, 1);
        run_instr(2'b10, 6'b000000, 0, 0);
        repeat (40) rand_instr();
        do_reset();

        run_instr(2'b00, 6'b001000, 0, 0);
        run_instr(2'b01, 6'b011001, 1, 0);
        run_instr(2'b01, 6'b011000, 0, 0);
        run_instr(2'b10, 6'b000000, 0, 0);
        run_instr(2'b11, 6'b000000, 0, 0);
        do_reset();

        Op    = 2'b01;
        Funct = 6'b011000;
        step(0, 1);
        step(1, 1);
        step(2, 1);
        mem_ready = 1'b0;
        #1;
        chk("abort_memw_pre", 32'(MemW), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_state", 32'(state_dbg), 32'd0);
        chk("abort_memw", 32'(MemW), 32'd0);
        do_reset();

        repeat (20) rand_instr();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main sequencing controller for the multicycle ARM datapath: a Moore-style FSM, plus per-cycle write enables gated by a memory handshake.
- Drives the mux selects, write enables, ALUOp and the ImmSrc field used by the immediate extender.
- Sits between the instruction register (Op/Funct fields) and the shared datapath/memory port.
- Inserts wait cycles on every memory access until mem_ready is asserted.

Parameters:
- STATE_W, 4, width of the state register and of the state_dbg port.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- Op  input  2  instruction register bits [27:26].
- Funct  input  6  instruction register bits [25:20] (I, cmd[3:0], S/L).
- mem_ready  input  1  memory completes the current access this cycle.
- IRWrite  output  1  instruction register load.
- NextPC  output  1  PC write for sequential fetch.
- RegW  output  1  register file write.
- MemW  output  1  memory write.
- Branch  output  1  PC write for taken branch (condition gating is external).
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUSrcA  output  2  00 = Rn reg, 01 = PC, 10 = ALUOut.
- ALUSrcB  output  2  00 = Rm reg, 01 = ExtImm, 10 = const 4.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add.
- ImmSrc  output  2  registered immediate format to the extender.
- illegal  output  1  FSM is in UNKNOWN.
- state_dbg  output  STATE_W  current state encoding.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Reset (asynchronous):
  - State goes to FETCH and ImmSrc to 00.
  - While reset is high, IRWrite, NextPC, RegW, MemW and Branch are all forced to 0.
  - After reset releases, the first active state is FETCH.
- Output values by state. Any output not listed for a state is 0/00.
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=mem_ready. Go to DECODE if mem_ready, else stay.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. ImmSrc<=Op on exit. Next state:
    - Op=00 & Funct[5]=0 -> EXECUTER.
    - Op=00 & Funct[5]=1 -> EXECUTEI.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=11 -> UNKNOWN.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Go to ALUWB.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Go to ALUWB.
  - ALUWB: ResultSrc=00. RegW=1 unless Funct[4:3]=10 (TST/TEQ/CMP/CMN), in which case RegW=0. Go to FETCH.
  - MEMADR: ALUSrcA=00, ALUSrcB=01. Go to MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD: AdrSrc=1. Go to MEMWB when mem_ready, else stay.
  - MEMWB: ResultSrc=01, RegW=1. Go to FETCH.
  - MEMWR: AdrSrc=1, MemW=1, held continuously while waiting. Go to FETCH when mem_ready, else stay.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1. Go to FETCH.
  - UNKNOWN: illegal=1, all enables 0. Sticky until reset.
- Illegal encodings 11-15: next state is UNKNOWN.
- Latency with mem_ready held high:
  - Data-processing (R or I): 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Each low mem_ready cycle during FETCH, MEMRD or MEMWR adds 1 cycle.
- ImmSrc changes only on the DECODE->next edge and is stable for the rest of the instruction.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted in any cycle with reset high.

Optional Feature:
- Macro: MCTRL_RETIRE_CNT_EN.
- When defined:
  - Adds output retired_cnt[31:0], reset to 0.
  - Increments by 1 on each transition into FETCH from ALUWB, MEMWB, MEMWR or BRANCH.
  - Wraps from 0xFFFFFFFF to 0.
  - Never increments in UNKNOWN.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset high for 3 cycles, then release with mem_ready=1 -> state_dbg=0 and all enables 0 during reset; IRWrite=NextPC=1 in the first cycle after release.
- ADD register (Op=00, Funct=001000), mem_ready=1 -> states 0,1,6,8,0; RegW=1 only in ALUWB; ALUOp=1 only in EXECUTER; ImmSrc=00.
- CMP immediate (Op=00, Funct=110101) -> states 0,1,7,8,0; ALUSrcB=01 in EXECUTEI; RegW=0 in ALUWB.
- LDR (Op=01, Funct=011001), mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with AdrSrc=1; then MEMWB with ResultSrc=01, RegW=1; ImmSrc=01.
- STR (Op=01, Funct=011000), mem_ready low for 1 cycle -> MemW=1 for 2 consecutive cycles, then FETCH; B (Op=10) -> Branch=1 for exactly 1 cycle, ImmSrc=10.
- Op=11 -> illegal=1, state_dbg=10, held for 20 cycles until reset; with MCTRL_RETIRE_CNT_EN defined, the preceding 4 instructions give retired_cnt=4, unchanged while in UNKNOWN.
